pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Stall/flush controller for the 5-stage pipeline. It sits beside the operand-forwarding logic and covers the hazards forwarding cannot resolve:
- load-use hazards
- structural/HI-LO hazards against the multicycle mult/div unit
- control hazards from taken branches

It drives the PC and IF/ID write enables and the IF/ID and ID/EX flushes, sequences the mult/div unit with an internal busy FSM, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is occupied after issue; legal range 2..63.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_Ra  in  5  rs field of the instruction in ID.
- id_Rb  in  5  rt field of the instruction in ID.
- id_useRa  in  1  ID instruction reads Ra.
- id_useRb  in  1  ID instruction reads Rb.
- id_isMD  in  1  ID instruction is mult/multu/div/divu.
- id_readsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- ex_Rw  in  5  destination register of the instruction in EX.
- ex_MemRead  in  1  EX instruction is a load.
- ex_branchTaken  in  1  branch/jump resolved taken in EX.
- pc_Wr  out  1  PC write enable.
- ifid_Wr  out  1  IF/ID register write enable.
- ifid_flush  out  1  zero IF/ID at next edge.
- idex_flush  out  1  insert bubble into ID/EX at next edge.
- md_start  out  1  one-cycle issue pulse to the mult/div unit.
- md_busy  out  1  mult/div unit occupied.
- stall_cnt  out  16  saturating count of stalled cycles.

## Operation
- load_use = ex_MemRead & (ex_Rw != 0) & ((id_useRa & ex_Rw == id_Ra) | (id_useRb & ex_Rw == id_Rb)).
- md_hazard = md_busy & (id_isMD | id_readsHiLo).
- stall = ~ex_branchTaken & (load_use | md_hazard).
- Priority: branch > load-use > md_hazard.
- Taken branch:
  - ifid_flush = 1, idex_flush = 1, pc_Wr = 1, ifid_Wr = 1.
  - Any ID-stage mult/div is squashed: no md_start.
- Stall: pc_Wr = 0, ifid_Wr = 0, idex_flush = 1, ifid_flush = 0.
- Otherwise: pc_Wr = 1, ifid_Wr = 1, both flushes 0.
- All four pipeline-control outputs are combinational from the current inputs and the FSM state.
- md_start = id_isMD & ~stall & ~ex_branchTaken, combinational. It is asserted in the cycle the mult/div leaves ID.
- Mult/div FSM, state register plus 6-bit down-counter md_cnt:
  - IDLE: md_busy = 0. On md_start, go to BUSY and load md_cnt = MD_LATENCY-1.
  - BUSY: md_busy = 1, md_cnt decrements each cycle.
  - BUSY, md_cnt == 0: go to IDLE at the next edge.
  - md_start cannot occur in BUSY, because md_hazard stalls it.
- stall_cnt:
  - Increments on every edge where pc_Wr == 0.
  - Holds at 16'hFFFF once reached (saturates, no wrap).
  - Cleared only by rst.

## Timing
- Reset values: state IDLE, md_cnt 0, md_busy 0, stall_cnt 0.
- With all inputs 0 during or after reset: pc_Wr 1, ifid_Wr 1, ifid_flush 0, idex_flush 0, md_start 0.
- rst asserted mid-BUSY: IDLE and md_busy 0 immediately (asynchronous). An ID-stage HI/LO reader is no longer stalled.
- Load-use costs exactly one stall cycle. The bubble reaching EX clears ex_MemRead, which releases the stall; there is no internal state for this.
- md_start at cycle T:
  - md_busy is high for cycles T+1 .. T+MD_LATENCY.
  - An HI/LO reader or a second mult/div held in ID issues at T+MD_LATENCY+1.
- A taken branch in the same cycle as load_use or md_hazard wins: no stall, both flushes, and stall_cnt does not increment.
- ex_Rw == 0 with a load never causes a stall.
- md_busy is not cleared by a branch flush. An issued mult/div always completes.

## Test plan
- Load-use hit: lw $5 in EX (ex_MemRead=1, ex_Rw=5), ID id_Ra=5, id_useRa=1 -> one cycle pc_Wr=0, ifid_Wr=0, idex_flush=1, stall_cnt=1. Next cycle, with ex_MemRead=0, outputs return to normal.
- Load-use on $0 or an unused operand: ex_Rw=0, or id_useRb=0 with id_Rb matching -> no stall, stall_cnt stays 0.
- Mult/div sequencing, MD_LATENCY=4: mult in ID at T -> md_start=1 at T, md_busy 1 at T+1..T+4. mfhi in ID from T+1 stalls T+1..T+4 and issues at T+5. stall_cnt=4.
- Branch priority: ex_branchTaken=1 together with load_use=1 and id_isMD=1 -> pc_Wr=1, ifid_flush=1, idex_flush=1, md_start=0, stall_cnt unchanged.
- Reset mid-operation: assert rst at BUSY md_cnt=2 -> md_busy=0 immediately, stall_cnt=0. After release, mfhi in ID issues without stall.
- Saturation: force 65540 consecutive load-use stalls -> stall_cnt reaches 16'hFFFF and holds.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX pipeline and the hazard controller.
//   ID fields : id_Ra, id_Rb, id_useRa, id_useRb, id_isMD, id_readsHiLo
//   EX fields : ex_Rw, ex_MemRead, ex_branchTaken
//   controls  : pc_Wr, ifid_Wr, ifid_flush, idex_flush
//   mult/div  : md_start, md_busy
//   stats     : stall_cnt
// master = pipeline side (drives ID/EX info), slave = hazard controller.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_Ra;
    logic [4:0]  id_Rb;
    logic        id_useRa;
    logic        id_useRb;
    logic        id_isMD;
    logic        id_readsHiLo;
    logic [4:0]  ex_Rw;
    logic        ex_MemRead;
    logic        ex_branchTaken;
    logic        pc_Wr;
    logic        ifid_Wr;
    logic        ifid_flush;
    logic        idex_flush;
    logic        md_start;
    logic        md_busy;
    logic [15:0] stall_cnt;

    modport master (
        output id_Ra, id_Rb, id_useRa, id_useRb, id_isMD, id_readsHiLo,
               ex_Rw, ex_MemRead, ex_branchTaken,
        input  pc_Wr, ifid_Wr, ifid_flush, idex_flush, md_start, md_busy,
               stall_cnt
    );

    modport slave (
        input  id_Ra, id_Rb, id_useRa, id_useRb, id_isMD, id_readsHiLo,
               ex_Rw, ex_MemRead, ex_branchTaken,
        output pc_Wr, ifid_Wr, ifid_flush, idex_flush, md_start, md_busy,
               stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Resolves load-use hazards, mult/div (HI/LO) structural hazards and taken
// branch control hazards; sequences the multicycle mult/div unit with a busy
// FSM and keeps a saturating count of stalled cycles.
// Ports:
//   clk  - pipeline clock, rising edge
//   rst  - asynchronous active-high reset
//   hz   - hazard bundle (slave side): ID/EX info in, pipeline controls,
//          md_start/md_busy and stall_cnt out
// Parameter MD_LATENCY (2..63): cycles the mult/div unit is busy after issue.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t   md_state;
    logic [5:0]  md_cnt;
    logic        md_busy_q;
    logic [15:0] stall_cnt_q;

    logic load_use, md_hazard, stall, md_start;
    logic pc_wr, ifid_wr, ifid_flush, idex_flush;

    // $0 is never a real dependency, and an operand only counts if it is read.
    assign load_use = hz.ex_MemRead && (hz.ex_Rw != 5'd0) &&
                      ((hz.id_useRa && (hz.ex_Rw == hz.id_Ra)) ||
                       (hz.id_useRb && (hz.ex_Rw == hz.id_Rb)));
    assign md_hazard = md_busy_q && (hz.id_isMD || hz.id_readsHiLo);
    // A taken branch squashes the ID instruction, so its hazards are moot.
    assign stall    = !hz.ex_branchTaken && (load_use || md_hazard);
    assign md_start = hz.id_isMD && !stall && !hz.ex_branchTaken;

    always_comb begin
        pc_wr      = 1'b1;
        ifid_wr    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (hz.ex_branchTaken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            pc_wr      = 1'b0;
            ifid_wr    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Mult/div occupancy: busy for exactly MD_LATENCY cycles after issue.
    // md_start cannot arrive while BUSY since md_hazard stalls it in ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_state  <= IDLE;
            md_cnt    <= 6'd0;
            md_busy_q <= 1'b0;
        end else begin
            case (md_state)
                IDLE: if (md_start) begin
                    md_state  <= BUSY;
                    md_cnt    <= 6'(MD_LATENCY - 1);
                    md_busy_q <= 1'b1;
                end
                BUSY: if (md_cnt == 6'd0) begin
                    md_state  <= IDLE;
                    md_busy_q <= 1'b0;
                end else begin
                    md_cnt <= md_cnt - 6'd1;
                end
                default: begin
                    md_state  <= IDLE;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= 16'd0;
        else if (!pc_wr && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign hz.pc_Wr      = pc_wr;
    assign hz.ifid_Wr    = ifid_wr;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_flush = idex_flush;
    assign hz.md_start   = md_start;
    assign hz.md_busy    = md_busy_q;
    assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized check of pipeline_hazard_ctrl against a cycle-numbered model:
// mult/div occupancy is tracked as the last busy cycle number, the stall
// count as a plain saturating integer.
module tb_pipeline_hazard_ctrl;
    localparam int MD_L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz ();
    pipeline_hazard_ctrl #(.MD_LATENCY(MD_L)) dut (.clk(clk), .rst(rst), .hz(hz));

    int    n_vec  = 0;
    int    n_bad  = 0;
    longint cyc    = 0;
    longint md_end = -1;   // last cycle number in which md_busy is expected
    int    stall_m = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [4:0] ra, rb, rw,
                         input logic ua, ub, md, hl, mr, br);
        hz.id_Ra = ra; hz.id_Rb = rb; hz.ex_Rw = rw;
        hz.id_useRa = ua; hz.id_useRb = ub; hz.id_isMD = md;
        hz.id_readsHiLo = hl; hz.ex_MemRead = mr; hz.ex_branchTaken = br;
    endtask

    // One pipeline cycle: apply inputs, compare every output, advance model.
    task automatic step(input logic [4:0] ra, rb, rw,
                        input logic ua, ub, md, hl, mr, br);
        logic busy_m, lu, st, e_pc, e_mds;
        @(negedge clk);
        drive(ra, rb, rw, ua, ub, md, hl, mr, br);
        #1;
        busy_m = (cyc <= md_end);
        lu     = mr && (rw != 0) && ((ua && rw == ra) || (ub && rw == rb));
        st     = !br && (lu || (busy_m && (md || hl)));
        e_pc   = !st;
        e_mds  = md && !st && !br;
        chk("pc_Wr",      32'(hz.pc_Wr),      32'(e_pc));
        chk("ifid_Wr",    32'(hz.ifid_Wr),    32'(e_pc));
        chk("ifid_flush", 32'(hz.ifid_flush), 32'(br));
        chk("idex_flush", 32'(hz.idex_flush), 32'(br || st));
        chk("md_start",   32'(hz.md_start),   32'(e_mds));
        chk("md_busy",    32'(hz.md_busy),    32'(busy_m));
        chk("stall_cnt",  32'(hz.stall_cnt),  32'(stall_m));
        if (e_mds) md_end = cyc + MD_L;
        if (!e_pc && stall_m < 65535) stall_m++;
        cyc++;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_pc_Wr",      32'(hz.pc_Wr),      1);
        chk("rst_ifid_Wr",    32'(hz.ifid_Wr),    1);
        chk("rst_ifid_flush", 32'(hz.ifid_flush), 0);
        chk("rst_idex_flush", 32'(hz.idex_flush), 0);
        chk("rst_md_start",   32'(hz.md_start),   0);
        chk("rst_md_busy",    32'(hz.md_busy),    0);
        chk("rst_stall_cnt",  32'(hz.stall_cnt),  0);
        #2 rst = 1'b0;

        // load-use hit, then released by the bubble
        step(5, 0, 5, 1, 0, 0, 0, 1, 0);
        step(5, 0, 5, 1, 0, 0, 0, 0, 0);
        // load to $0, unused matching Rb: no stall
        step(0, 0, 0, 1, 1, 0, 0, 1, 0);
        step(1, 7, 7, 1, 0, 0, 0, 1, 0);
        // mult issue, mfhi waits out the busy window then issues
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < MD_L + 1; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        // branch beats load-use and an ID mult
        step(3, 0, 3, 1, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // randomized mix biased toward hazards
        for (int i = 0; i < 3000; i++)
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));

        // reset while BUSY: busy drops at once, HI/LO reader no longer stalled
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        rst = 1'b1;
        #1;
        chk("arst_md_busy",   32'(hz.md_busy),   0);
        chk("arst_stall_cnt", 32'(hz.stall_cnt), 0);
        chk("arst_pc_Wr",     32'(hz.pc_Wr),     1);
        #1 rst = 1'b0;
        md_end = -1;
        stall_m = 0;
        cyc++;
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // saturation: long run of load-use stalls
        for (int i = 0; i < 65540; i++) step(5, 0, 5, 1, 0, 0, 0, 1, 0);
        chk("sat_stall_cnt", 32'(hz.stall_cnt), 32'h0000FFFF);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
